fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the 16-entry x 16-bit combinational program ROM and downstream feeds decode.
- Holds the program counter, drives the ROM address, registers the returned instruction and hands it to decode over a valid/ready handshake.
- Supports a branch/jump redirect, a halt request and an accepted-instruction counter.

Parameters:
- ADDR_W, 4, program-counter / ROM address width.
- INST_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_address  out  ADDR_W  address to program ROM; equals current PC register.
- rom_instruction  in  INST_W  ROM read data, combinational from rom_address.
- if_valid  out  1  output register holds an instruction for decode.
- if_ready  in  1  decode accepts this cycle.
- if_instruction  out  INST_W  fetched instruction.
- if_pc  out  ADDR_W  address the instruction was fetched from.
- redirect_valid  in  1  load new PC, flush output register.
- redirect_pc  in  ADDR_W  redirect target.
- halt  in  1  stop fetching.
- halted  out  1  high while in HALTED state.
- fetch_count  out  CNT_W  handshakes completed (if_valid && if_ready).

Behaviour:
- Reset (rst=1 at edge, overrides everything): pc=RESET_PC, if_valid=0, if_instruction=0, if_pc=0, state=RUN, halted=0, fetch_count=0. Reset mid-stream discards the held instruction.
- rom_address = pc at all times (no extra register).
- load = (state==RUN) && (!if_valid || if_ready).
- States: RUN, HALTED. halted = (state==HALTED).
- Per cycle, priority order:
  1. redirect_valid: pc<=redirect_pc; if_valid<=0; state<=RUN; no load this cycle, even if halt is also high.
  2. halt (in RUN): state<=HALTED. No new load this cycle; an already valid output stays valid until accepted.
  3. load: if_instruction<=rom_instruction; if_pc<=pc; if_valid<=1; pc<=pc+1, modulo 2^ADDR_W (15 wraps to 0).
  4. if_valid && if_ready without load (HALTED drain): if_valid<=0.
  5. Otherwise hold all registers; outputs stable under backpressure.
- Latency: address N on rom_address in cycle t gives if_pc=N and if_valid=1 in cycle t+1. Throughput is one instruction per cycle with if_ready=1.
- Redirect bubble: one cycle with if_valid=0, then target instruction.
- HALTED: pc frozen; only redirect_valid or rst leave it. halt held high in HALTED has no effect.
- fetch_count increments by 1 on each cycle with if_valid && if_ready, including the cycle a redirect flushes it. Wraps at 2^CNT_W.
- if_instruction and if_pc change only on load or reset.

Decomposition:
- Shared package cpu_pkg: ADDR_W, INST_W, fetch state encoding (ST_RUN=1'b0, ST_HALTED=1'b1), RESET_PC default.
- No sub-module. PC, output register, FSM and counter all live in fetch_unit.
- Bench instantiates the existing program ROM model, or a behavioural ROM with mem[k]=16'h1000+k.

Test Plan:
1. rst 2 cycles, then if_ready=1 for 18 cycles -> first cycle after reset if_valid=1, if_pc=0, if_instruction=16'h1000; if_pc walks 0..15, then 0, 1; fetch_count=18.
2. Valid at if_pc=2, if_ready=0 for 3 cycles -> if_pc=2, if_instruction=16'h1002, rom_address=3 held stable; fetch_count unchanged; if_ready=1 -> next if_pc=3.
3. redirect_valid=1, redirect_pc=9 while if_pc=4 valid and if_ready=0 -> next cycle if_valid=0, rom_address=9; cycle after if_pc=9, if_instruction=16'h1009.
4. halt pulse while if_pc=5 valid, if_ready=0 for 2 cycles then 1 -> halted=1 next cycle; pc=6 frozen; if_pc=5 accepted once, then if_valid=0 indefinitely. redirect_pc=0 -> halted=0, then if_pc=0 appears.
5. rst one cycle while if_valid=1, if_pc=7, fetch_count=7 -> next cycle if_valid=0, if_pc=0, if_instruction=0, fetch_count=0, rom_address=0.
6. halt=1 and redirect_valid=1 (redirect_pc=12) same cycle -> halted stays 0, one bubble, then if_pc=12, if_instruction=16'h100C.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned INST_W   = 16;
  localparam int unsigned RESET_PC = 0;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake carrying the instruction and its PC.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned INST_W = cpu_pkg::INST_W
);

  logic              if_valid;
  logic              if_ready;
  logic [INST_W-1:0] if_instruction;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    output if_valid,
    output if_instruction,
    output if_pc,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_instruction,
    input  if_pc,
    output if_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM addressing, output register, RUN/HALTED
// control and a count of instructions accepted by decode.
module fetch_unit #(
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned INST_W   = cpu_pkg::INST_W,
  parameter int unsigned RESET_PC = cpu_pkg::RESET_PC,
  parameter int unsigned CNT_W    = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [INST_W-1:0] rom_instruction,
  fetch_unit_if.master      dec,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              handshake;
  logic              load;

  assign handshake = valid_q && dec.if_ready;
  assign load      = (state_q == ST_RUN) && (!valid_q || dec.if_ready);

  // Next-state logic: redirect beats halt beats load beats drain.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q + CNT_W'(handshake);

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (halt && (state_q == ST_RUN)) begin
      state_d = ST_HALTED;
      if (handshake) begin
        valid_d = 1'b0;
      end
    end else if (load) begin
      inst_d  = rom_instruction;
      ipc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + ADDR_W'(1);
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    halted_d = (state_d == ST_HALTED);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= ADDR_W'(RESET_PC);
      valid_q  <= 1'b0;
      inst_q   <= '0;
      ipc_q    <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rom_address        = pc_q;
  assign dec.if_valid       = valid_q;
  assign dec.if_instruction = inst_q;
  assign dec.if_pc          = ipc_q;
  assign halted             = halted_q;
  assign fetch_count        = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a rule-level reference model.
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned INST_W = 16;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rom_address;
  logic [INST_W-1:0] rom_instruction;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dec_if ();

  fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .dec             (dec_if.master),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  // Behavioural program ROM: mem[k] = 16'h1000 + k.
  assign rom_instruction = 16'h1000 + {12'h000, rom_address};

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int m_pc, m_ipc, m_inst, m_cnt;
  bit m_valid, m_halted;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Advance the model one clock using the inputs currently driven.
  task automatic model_step();
    bit acc;
    if (rst) begin
      m_pc = 0; m_ipc = 0; m_inst = 0; m_cnt = 0; m_valid = 0; m_halted = 0;
      return;
    end
    acc   = m_valid && dec_if.if_ready;
    m_cnt = (m_cnt + int'(acc)) % 65536;
    if (redirect_valid) begin
      m_pc = int'(redirect_pc); m_valid = 0; m_halted = 0;
    end else if (m_halted || halt) begin
      m_halted = 1;
      if (acc) m_valid = 0;
    end else if (!m_valid || dec_if.if_ready) begin
      m_inst  = 'h1000 + m_pc;
      m_ipc   = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 16;
    end else if (acc) begin
      m_valid = 0;
    end
  endtask

  // One clock: step the model, let the edge pass, compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("rom_address", int'(rom_address), m_pc);
    check("if_valid", int'(dec_if.if_valid), int'(m_valid));
    check("halted", int'(halted), int'(m_halted));
    check("fetch_count", int'(fetch_count), m_cnt);
    if (m_valid || rst) begin
      check("if_pc", int'(dec_if.if_pc), m_ipc);
      check("if_instruction", int'(dec_if.if_instruction), m_inst);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1; dec_if.if_ready = 0; redirect_valid = 0; redirect_pc = '0; halt = 0;
    m_pc = 0; m_ipc = 0; m_inst = 0; m_cnt = 0; m_valid = 0; m_halted = 0;
    @(negedge clk);

    // 1: reset then streaming with if_ready high
    ticks(2);
    check("t1_reset_valid", int'(dec_if.if_valid), 0);
    check("t1_reset_count", int'(fetch_count), 0);
    check("t1_reset_addr", int'(rom_address), 0);
    rst = 0; dec_if.if_ready = 1;
    tick();
    check("t1_first_valid", int'(dec_if.if_valid), 1);
    check("t1_first_pc", int'(dec_if.if_pc), 0);
    check("t1_first_inst", int'(dec_if.if_instruction), 'h1000);
    ticks(15);
    check("t1_pc15", int'(dec_if.if_pc), 15);
    tick();
    check("t1_wrap_pc0", int'(dec_if.if_pc), 0);
    ticks(2);
    check("t1_pc2", int'(dec_if.if_pc), 2);
    check("t1_count18", int'(fetch_count), 18);

    // 2: backpressure holds everything
    dec_if.if_ready = 0;
    ticks(3);
    check("t2_hold_pc", int'(dec_if.if_pc), 2);
    check("t2_hold_inst", int'(dec_if.if_instruction), 'h1002);
    check("t2_hold_addr", int'(rom_address), 3);
    check("t2_hold_count", int'(fetch_count), 18);
    dec_if.if_ready = 1;
    tick();
    check("t2_next_pc", int'(dec_if.if_pc), 3);
    tick();
    check("t2_pc4", int'(dec_if.if_pc), 4);

    // 3: redirect while stalled
    dec_if.if_ready = 0; redirect_valid = 1; redirect_pc = 4'd9;
    tick();
    check("t3_bubble", int'(dec_if.if_valid), 0);
    check("t3_addr9", int'(rom_address), 9);
    redirect_valid = 0;
    tick();
    check("t3_pc9", int'(dec_if.if_pc), 9);
    check("t3_inst9", int'(dec_if.if_instruction), 'h1009);

    // 4: halt with a valid output pending
    redirect_valid = 1; redirect_pc = 4'd5;
    tick();
    redirect_valid = 0;
    tick();
    check("t4_pc5", int'(dec_if.if_pc), 5);
    halt = 1;
    tick();
    check("t4_halted", int'(halted), 1);
    check("t4_still_valid", int'(dec_if.if_valid), 1);
    halt = 0;
    tick();
    dec_if.if_ready = 1;
    tick();
    check("t4_drained", int'(dec_if.if_valid), 0);
    halt = 1;
    ticks(3);
    check("t4_frozen_addr", int'(rom_address), 6);
    check("t4_stay_empty", int'(dec_if.if_valid), 0);
    halt = 0; redirect_valid = 1; redirect_pc = 4'd0;
    tick();
    check("t4_unhalt", int'(halted), 0);
    redirect_valid = 0;
    tick();
    check("t4_pc0", int'(dec_if.if_pc), 0);
    check("t4_valid", int'(dec_if.if_valid), 1);

    // 5: reset mid-stream discards the held instruction
    rst = 1;
    tick();
    rst = 0;
    ticks(8);
    check("t5_pre_pc7", int'(dec_if.if_pc), 7);
    check("t5_pre_cnt7", int'(fetch_count), 7);
    rst = 1;
    tick();
    check("t5_valid0", int'(dec_if.if_valid), 0);
    check("t5_pc0", int'(dec_if.if_pc), 0);
    check("t5_inst0", int'(dec_if.if_instruction), 0);
    check("t5_cnt0", int'(fetch_count), 0);
    check("t5_addr0", int'(rom_address), 0);

    // 6: redirect wins over a simultaneous halt
    rst = 0; dec_if.if_ready = 0;
    tick();
    halt = 1; redirect_valid = 1; redirect_pc = 4'd12;
    tick();
    check("t6_not_halted", int'(halted), 0);
    check("t6_bubble", int'(dec_if.if_valid), 0);
    halt = 0; redirect_valid = 0;
    tick();
    check("t6_pc12", int'(dec_if.if_pc), 12);
    check("t6_inst", int'(dec_if.if_instruction), 'h100C);
    check("t6_halted0", int'(halted), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
